memory_boot_ram: RTL and testbench
==================================

// Module: memory_boot_ram
// PURPOSE
//  Word-addressed main memory that is the responder on the CPU bus: it answers MAR/write/MBR_W with MBR_R.
//  Contains a byte-serial boot loader FSM that fills memory from address 0 after reset.
//  cpu_hold keeps the CPU in reset until loading finishes. It drives the CPU reset as (reset | cpu_hold).
// PARAMETERS
//  BITS_DATA   32  data word width
//  BITS_ADDR   16  bus address width (MAR)
//  DEPTH_BITS  10  implemented words = 2**DEPTH_BITS; MAR[DEPTH_BITS-1:0] is used, upper bits are ignored (aliasing)
//  BOOT_EN     1   1: reset enters LOAD; 0: reset enters RUN directly
// PORTS
//  clk         in   1          system clock, all state changes on posedge
//  reset       in   1          synchronous, active-high
//  MAR         in   BITS_ADDR  CPU address
//  MBR_W       in   BITS_DATA  CPU write data
//  write       in   1          CPU write strobe, sampled on posedge
//  MBR_R       out  BITS_DATA  read data = mem[MAR], combinational
//  load_byte   in   8          boot byte
//  load_valid  in   1          load_byte is valid
//  load_last   in   1          qualifies the final byte of the image
//  load_ready  out  1          loader accepts a byte this cycle
//  cpu_hold    out  1          1 while in LOAD/COMMIT
//  load_count  out  DEPTH_BITS+1  words committed since last reset
// BEHAVIOUR
//  Reset (sync):
//   - state=LOAD (or RUN if BOOT_EN=0), load_addr=0, byte_cnt=0, asm=0, load_count=0.
//   - Memory contents are NOT cleared. Any partial word is discarded.
//   - Reset mid-load restarts the load at address 0.
//  Outputs by state:
//   - LOAD: load_ready=1, cpu_hold=1. COMMIT: load_ready=0, cpu_hold=1. RUN: load_ready=0, cpu_hold=0.
//  LOAD, on load_valid & load_ready:
//   - asm <= {asm[23:0], load_byte} (big-endian: first byte lands in [31:24]).
//   - byte_cnt++.
//   - On 4th byte OR load_last: go to COMMIT.
//   - If load_last arrives early, the remaining low bytes are zero-padded (word = bytes << 8*(4-n)).
//   - The load_last flag is latched.
//  COMMIT (exactly 1 cycle):
//   - mem[load_addr] <= word; load_addr++; load_count++; byte_cnt <= 0.
//   - Next state is RUN if last was latched OR load_addr == 2**DEPTH_BITS-1 (memory full); otherwise LOAD.
//   - load_addr never wraps.
//  RUN:
//   - write=1 at posedge: mem[MAR[DEPTH_BITS-1:0]] <= MBR_W.
//   - MBR_R reflects a new MAR in the same cycle. The CPU samples it one edge after driving MAR.
//   - Read-during-write to the same address: MBR_R shows the old data until the edge, then the new data.
//   - RUN persists until reset; load_valid is ignored.
//  In LOAD/COMMIT:
//   - CPU write is ignored.
//   - MBR_R stays combinational on MAR (don't-care to the held CPU).
//  load_count saturates at 2**DEPTH_BITS.
//  Latency:
//   - 4 accepted bytes -> word in memory at the end of the following (COMMIT) cycle.
//   - cpu_hold falls on the cycle after the final COMMIT.
// TESTING
//  1. Reset, then send bytes 0x08,0x01,0x00,0x05 with last on the 4th -> mem[0]=0x08010005, load_count=1, cpu_hold=0 two cycles after the last byte.
//  2. Send 6 bytes 11,22,33,44,55,66 with last on the 6th -> mem[0]=0x11223344, mem[1]=0x55660000, load_count=2.
//  3. RUN: write=1, MAR=0x0005, MBR_W=0xDEADBEEF; next cycle write=0 -> MBR_R=0xDEADBEEF. MAR=0x0405 with DEPTH_BITS=10 -> same data (alias).
//  4. Stall load_valid low for 5 cycles mid-word, then apply reset after 2 bytes:
//     - No partial commit, load_addr=0, load_count=0.
//     - A fresh 4-byte word is written to mem[0]; earlier RUN contents elsewhere survive.
//  5. DEPTH_BITS=2, stream 5 words without last -> 4 words committed, RUN entered, load_ready=0, 5th word not written, load_count=4.
//  6. BOOT_EN=0 -> cpu_hold=0 and load_ready=0 immediately after reset; a CPU write followed by a read returns the written value.

Source files
------------

// File: rtl/memory_boot_ram.sv
// Word-addressed CPU bus memory with a byte-serial boot loader.
// After reset the loader fills memory from address 0 while cpu_hold keeps the CPU in reset.
module memory_boot_ram #(
  parameter int BITS_DATA  = 32,
  parameter int BITS_ADDR  = 16,
  parameter int DEPTH_BITS = 10,
  parameter bit BOOT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS_ADDR-1:0]  MAR,
  input  logic [BITS_DATA-1:0]  MBR_W,
  input  logic                  write,
  output logic [BITS_DATA-1:0]  MBR_R,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_hold,
  output logic [DEPTH_BITS:0]   load_count
);
  localparam int BYTES = BITS_DATA / 8;
  localparam int WORDS = 2 ** DEPTH_BITS;
  localparam int CW    = $clog2(BYTES + 1);

  typedef enum logic [1:0] {LOAD, COMMIT, RUN} state_t;

  state_t                  state;
  logic [DEPTH_BITS-1:0]   load_addr;
  logic [CW-1:0]           byte_cnt;
  logic [BITS_DATA-1:0]    asm_q, asm_next;
  logic                    last_q;
  logic [BITS_DATA-1:0]    mem [WORDS];
  logic                    unused_mar_hi;

  assign unused_mar_hi = ^MAR[BITS_ADDR-1:DEPTH_BITS];
  assign MBR_R = mem[MAR[DEPTH_BITS-1:0]];

  // Bytes are dropped into their big-endian lane of a cleared word, so an
  // early load_last leaves the remaining low bytes already zero-padded.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < BYTES; i++)
      if (CW'(i) == byte_cnt) asm_next[BITS_DATA-8-8*i +: 8] = load_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT_EN ? LOAD : RUN;
      load_ready <= BOOT_EN;
      cpu_hold   <= BOOT_EN;
      load_addr  <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      last_q     <= 1'b0;
      load_count <= '0;
    end else begin
      case (state)
        LOAD: if (load_valid) begin
          asm_q    <= asm_next;
          byte_cnt <= byte_cnt + 1'b1;
          last_q   <= load_last;
          if (load_last || byte_cnt == CW'(BYTES - 1)) begin
            state      <= COMMIT;
            load_ready <= 1'b0;
          end
        end
        COMMIT: begin
          byte_cnt <= '0;
          asm_q    <= '0;
          if (load_count != (DEPTH_BITS+1)'(WORDS)) load_count <= load_count + 1'b1;
          // load_addr parks on the last word rather than wrapping to 0
          if (last_q || load_addr == '1) begin
            state    <= RUN;
            cpu_hold <= 1'b0;
          end else begin
            load_addr  <= load_addr + 1'b1;
            state      <= LOAD;
            load_ready <= 1'b1;
          end
        end
        RUN: ;
        default: begin
          state      <= RUN;
          load_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == COMMIT)
      mem[load_addr] <= asm_q;
    else if (!reset && state == RUN && write)
      mem[MAR[DEPTH_BITS-1:0]] <= MBR_W;
  end
endmodule

// File: tb/tb_memory_boot_ram.sv
// Randomized bench for memory_boot_ram: transaction-level model of the boot image
// and CPU memory, compared every cycle, plus literal checks of the directed scenarios.
module tb_memory_boot_ram;
  logic        clk = 1'b0;
  logic        reset = 1'b1, s_reset = 1'b1, n_reset = 1'b1;
  logic [15:0] MAR = '0;
  logic [31:0] MBR_W = '0;
  logic        write = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_valid = 1'b0, load_last = 1'b0;

  logic [31:0] MBR_R, s_MBR_R, n_MBR_R;
  logic        load_ready, cpu_hold, s_ready, s_hold, n_ready, n_hold;
  logic [10:0] load_count, n_count;
  logic [2:0]  s_count;

  memory_boot_ram u_dut (
    .clk(clk), .reset(reset), .MAR(MAR), .MBR_W(MBR_W), .write(write), .MBR_R(MBR_R),
    .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(load_ready), .cpu_hold(cpu_hold), .load_count(load_count));

  memory_boot_ram #(.DEPTH_BITS(2)) u_small (
    .clk(clk), .reset(s_reset), .MAR(MAR), .MBR_W(MBR_W), .write(write), .MBR_R(s_MBR_R),
    .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(s_ready), .cpu_hold(s_hold), .load_count(s_count));

  memory_boot_ram #(.BOOT_EN(1'b0)) u_nb (
    .clk(clk), .reset(n_reset), .MAR(MAR), .MBR_W(MBR_W), .write(write), .MBR_R(n_MBR_R),
    .load_byte(load_byte), .load_valid(load_valid), .load_last(load_last),
    .load_ready(n_ready), .cpu_hold(n_hold), .load_count(n_count));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  // model: memory image, pending boot bytes, expected status outputs
  logic [31:0] m_mem [1024];
  bit          m_known [1024];
  logic [7:0]  q [$];
  bit          e_ready, e_hold, m_run;
  int          e_count, m_addr;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("load_ready", 32'(load_ready), 32'(e_ready));
    chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
    chk("load_count", 32'(load_count), 32'(e_count));
    if (m_known[MAR[9:0]]) chk("mbr_r", MBR_R, m_mem[MAR[9:0]]);
  end

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; write = 1'b0;
    cyc();
    reset = 1'b0;
    e_ready = 1'b1; e_hold = 1'b1; e_count = 0; m_addr = 0; m_run = 1'b0;
    q.delete();
  endtask

  task automatic stall(input int n);
    load_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Loader-phase CPU traffic is random and must be ignored.
  task automatic send_byte(input logic [7:0] b, input bit last);
    logic [31:0] w;
    bit full;
    load_byte = b; load_last = last; load_valid = 1'b1;
    write = 1'($urandom_range(0, 1)); MAR = 16'($urandom); MBR_W = $urandom;
    cyc();
    load_valid = 1'b0; load_last = 1'b0; write = 1'b0;
    q.push_back(b);
    if (q.size() == 4 || last) begin
      e_ready = 1'b0;
      load_valid = 1'($urandom_range(0, 1)); load_byte = 8'($urandom);
      write = 1'($urandom_range(0, 1));
      cyc();
      load_valid = 1'b0; write = 1'b0;
      w = '0;
      for (int i = 0; i < q.size(); i++) w[31-8*i -: 8] = q[i];
      m_mem[m_addr] = w; m_known[m_addr] = 1'b1;
      if (e_count < 1024) e_count++;
      full = (m_addr == 1023);
      if (!full) m_addr++;
      q.delete();
      if (last || full) begin e_hold = 1'b0; m_run = 1'b1; end
      else e_ready = 1'b1;
    end
  endtask

  task automatic run_cyc(input logic [15:0] a, input logic [31:0] d, input bit w);
    MAR = a; MBR_W = d; write = w;
    if (m_run) load_valid = 1'($urandom_range(0, 1));
    cyc();
    if (m_run && w) begin m_mem[a[9:0]] = d; m_known[a[9:0]] = 1'b1; end
    write = 1'b0; load_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd_addr();
    return 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 63)) << 10);
  endfunction

  initial begin
    logic [7:0] img1 [4];
    logic [7:0] img2 [6];
    img1 = '{8'h08, 8'h01, 8'h00, 8'h05};
    img2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // reset all three; the non-boot instance must come up running
    reset = 1'b1; n_reset = 1'b1; s_reset = 1'b1;
    cyc();
    reset = 1'b0; n_reset = 1'b0;
    e_ready = 1'b1; e_hold = 1'b1; e_count = 0; m_addr = 0; m_run = 1'b0;
    chk_en = 1'b1;
    chk("t6_hold", 32'(n_hold), 32'd0);
    chk("t6_ready", 32'(n_ready), 32'd0);
    run_cyc(16'h0007, 32'hCAFE0007, 1'b1);
    MAR = 16'h0007; #1;
    chk("t6_readback", n_MBR_R, 32'hCAFE0007);

    // single word, last on 4th byte
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(img1[i], i == 3);
    MAR = 16'h0000; #1;
    chk("t1_word", MBR_R, 32'h08010005);
    chk("t1_count", 32'(load_count), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);

    // six bytes, second word zero-padded, with a stall inside
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) stall(3);
      send_byte(img2[i], i == 5);
    end
    MAR = 16'h0000; #1;
    chk("t2_word0", MBR_R, 32'h11223344);
    MAR = 16'h0001; #1;
    chk("t2_word1", MBR_R, 32'h55660000);
    chk("t2_count", 32'(load_count), 32'd2);

    // CPU write, then aliased read
    run_cyc(16'h0005, 32'hDEADBEEF, 1'b1);
    MAR = 16'h0005; #1;
    chk("t3_read", MBR_R, 32'hDEADBEEF);
    MAR = 16'h0405; #1;
    chk("t3_alias", MBR_R, 32'hDEADBEEF);
    for (int i = 0; i < 60; i++) run_cyc(rnd_addr(), $urandom, 1'($urandom_range(0, 1)));

    // stall mid-word, reset after two bytes, then a fresh word
    do_reset();
    send_byte(8'hA1, 1'b0);
    stall(5);
    send_byte(8'hA2, 1'b0);
    do_reset();
    chk("t4_count", 32'(load_count), 32'd0);
    chk("t4_ready", 32'(load_ready), 32'd1);
    send_byte(8'hC0, 1'b0); send_byte(8'hFF, 1'b0);
    send_byte(8'hEE, 1'b0); send_byte(8'h01, 1'b1);
    MAR = 16'h0000; #1;
    chk("t4_word0", MBR_R, 32'hC0FFEE01);
    chk("t4_count1", 32'(load_count), 32'd1);

    // random images and random CPU traffic
    for (int r = 0; r < 3; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
        send_byte(8'($urandom), i == n - 1);
      end
      for (int i = 0; i < 80; i++) run_cyc(rnd_addr(), $urandom, 1'($urandom_range(0, 1)));
    end

    // 4-word memory streamed 5 words with no last: fills and stops
    write = 1'b0;
    s_reset = 1'b1;
    cyc();
    s_reset = 1'b0;
    chk("t5_ready0", 32'(s_ready), 32'd1);
    chk("t5_hold0", 32'(s_hold), 32'd1);
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        load_byte = 8'(w * 16 + b); load_valid = 1'b1; load_last = 1'b0;
        cyc();
      end
      load_valid = 1'b0;
      cyc();
    end
    chk("t5_count", 32'(s_count), 32'd4);
    chk("t5_ready", 32'(s_ready), 32'd0);
    chk("t5_hold", 32'(s_hold), 32'd0);
    for (int w = 0; w < 4; w++) begin
      logic [31:0] ew;
      ew = {8'(w*16), 8'(w*16+1), 8'(w*16+2), 8'(w*16+3)};
      MAR = 16'(w); #1;
      chk("t5_word", s_MBR_R, ew);
    end

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
